// File: rtl/uart_boot_loader_if.sv
// Byte-stream, memory-write and boot-control signals between the boot loader
// and its surroundings (UART core, memory write port, CPU release).
interface uart_boot_loader_if;
    logic        rx_complete;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_complete;
    logic        mem_request;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        boot_start;
    logic [31:0] boot_address;
    logic        busy;

    modport master (
        input  rx_complete, rx_data, tx_complete, mem_ack,
        output tx_valid, tx_data, mem_request, mem_address, mem_wdata,
               boot_start, boot_address, busy
    );

    modport slave (
        output rx_complete, rx_data, tx_complete, mem_ack,
        input  tx_valid, tx_data, mem_request, mem_address, mem_wdata,
               boot_start, boot_address, busy
    );
endinterface

// File: rtl/uart_boot_loader.sv
// Target-side UART boot protocol responder: parses LOAD/RUN packets, writes
// payload words to memory, answers ACK/NAK and releases the CPU on a good RUN.
module uart_boot_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 5000000,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic               clock,
    input  logic               reset,
    uart_boot_loader_if.master bus
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_COUNT,
        S_DATA,
        S_CSUM,
        S_WAIT_MEM,
        S_RESPOND,
        S_BOOT
    } state_t;

    state_t      state;
    logic        is_run;
    logic [1:0]  byte_idx;
    logic [31:0] shift;
    logic [31:0] next_addr;
    logic [15:0] words_left;
    logic [7:0]  csum;
    logic        good;
    logic        overrun;
    logic [TW-1:0] timer;

    logic        tx_valid_r;
    logic [7:0]  tx_data_r;
    logic        mem_request_r;
    logic [31:0] mem_address_r;
    logic [31:0] mem_wdata_r;
    logic        boot_start_r;
    logic [31:0] boot_address_r;

    logic [31:0] shifted;
    logic        parsing;

    // Little-endian fields: each new byte enters at the top and slides down.
    assign shifted = {bus.rx_data, shift[31:8]};
    assign parsing = (state == S_ADDR) || (state == S_COUNT) ||
                     (state == S_DATA) || (state == S_CSUM);

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            is_run         <= 1'b0;
            byte_idx       <= '0;
            shift          <= '0;
            next_addr      <= '0;
            words_left     <= '0;
            csum           <= '0;
            good           <= 1'b0;
            overrun        <= 1'b0;
            timer          <= '0;
            tx_valid_r     <= 1'b0;
            tx_data_r      <= '0;
            mem_request_r  <= 1'b0;
            mem_address_r  <= '0;
            mem_wdata_r    <= '0;
            boot_start_r   <= 1'b0;
            boot_address_r <= '0;
        end else begin
            boot_start_r <= 1'b0;
            if (mem_request_r && bus.mem_ack)
                mem_request_r <= 1'b0;

            if (parsing && !bus.rx_complete)
                timer <= timer + 1'b1;
            else
                timer <= '0;

            if (parsing && !bus.rx_complete && timer == TIMER_LAST) begin
                // Abandon silently; an in-flight write still finishes on its own.
                state   <= S_IDLE;
                overrun <= 1'b0;
                timer   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.rx_complete &&
                            (bus.rx_data == 8'hB0 || bus.rx_data == 8'hB1)) begin
                            is_run   <= (bus.rx_data == 8'hB1);
                            csum     <= bus.rx_data;
                            overrun  <= 1'b0;
                            good     <= 1'b0;
                            byte_idx <= '0;
                            state    <= S_ADDR;
                        end
                    end

                    S_ADDR: begin
                        if (bus.rx_complete) begin
                            csum     <= csum + bus.rx_data;
                            shift    <= shifted;
                            byte_idx <= byte_idx + 1'b1;
                            if (byte_idx == 2'd3) begin
                                next_addr <= {shifted[31:2], 2'b00};
                                byte_idx  <= '0;
                                state     <= is_run ? S_CSUM : S_COUNT;
                            end
                        end
                    end

                    S_COUNT: begin
                        if (bus.rx_complete) begin
                            csum     <= csum + bus.rx_data;
                            shift    <= shifted;
                            byte_idx <= byte_idx + 1'b1;
                            if (byte_idx == 2'd1) begin
                                words_left <= shifted[31:16];
                                byte_idx   <= '0;
                                state      <= (shifted[31:16] == 16'd0) ? S_CSUM : S_DATA;
                            end
                        end
                    end

                    S_DATA: begin
                        if (bus.rx_complete) begin
                            csum     <= csum + bus.rx_data;
                            shift    <= shifted;
                            byte_idx <= byte_idx + 1'b1;
                            if (byte_idx == 2'd3) begin
                                byte_idx   <= '0;
                                next_addr  <= next_addr + 32'd4;
                                words_left <= words_left - 16'd1;
                                if (words_left == 16'd1)
                                    state <= S_CSUM;
                                // A request still pending (even in its ack cycle) means this word is lost.
                                if (mem_request_r) begin
                                    overrun <= 1'b1;
                                end else begin
                                    mem_request_r <= 1'b1;
                                    mem_address_r <= next_addr;
                                    mem_wdata_r   <= shifted;
                                end
                            end
                        end
                    end

                    S_CSUM: begin
                        if (bus.rx_complete) begin
                            good  <= (bus.rx_data == csum) && !overrun;
                            state <= S_WAIT_MEM;
                        end
                    end

                    S_WAIT_MEM: begin
                        if (!mem_request_r)
                            state <= S_RESPOND;
                    end

                    S_RESPOND: begin
                        if (!tx_valid_r) begin
                            tx_valid_r <= 1'b1;
                            tx_data_r  <= good ? ACK_BYTE : NAK_BYTE;
                        end else if (bus.tx_complete) begin
                            tx_valid_r <= 1'b0;
                            if (is_run && good) begin
                                boot_start_r   <= 1'b1;
                                boot_address_r <= next_addr;
                                state          <= S_BOOT;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end

                    S_BOOT: begin
                        state <= S_IDLE;
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.tx_valid     = tx_valid_r;
    assign bus.tx_data      = tx_data_r;
    assign bus.mem_request  = mem_request_r;
    assign bus.mem_address  = mem_address_r;
    assign bus.mem_wdata    = mem_wdata_r;
    assign bus.boot_start   = boot_start_r;
    assign bus.boot_address = boot_address_r;
    assign bus.busy         = (state != S_IDLE);
endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: host packets in, memory/tx/boot
// activity logged by small responders and compared to hand-computed values.
module tb_uart_boot_loader;
    typedef logic [7:0] byte_q_t[$];

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cycle = 0;

    uart_boot_loader_if bus();

    uart_boot_loader #(
        .TIMEOUT_CYCLES(100),
        .ACK_BYTE(8'h06),
        .NAK_BYTE(8'h15)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cycle++;

    int n_checks = 0;
    int n_bad    = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [7:0]  tx_q[$];
    int          tx_cycle     = 0;
    int          boot_cnt     = 0;
    int          boot_cycle   = 0;
    logic [31:0] boot_addr_seen = '0;
    int          stab_err     = 0;

    int ack_delay = 2;
    bit ack_en    = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wr_addr_at(input int i);
        return (wr_addr_q.size() > i) ? wr_addr_q[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] wr_data_at(input int i);
        return (wr_data_q.size() > i) ? wr_data_q[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] tx_at(input int i);
        return (tx_q.size() > i) ? {24'd0, tx_q[i]} : 32'hFFFF_FFFF;
    endfunction

    // Memory port model: acks ack_delay cycles after request, checks hold stability.
    initial begin
        logic        in_req;
        logic [31:0] cap_addr, cap_data;
        int          wait_cnt;
        bus.mem_ack = 1'b0;
        in_req = 1'b0;
        wait_cnt = 0;
        cap_addr = '0;
        cap_data = '0;
        forever begin
            @(negedge clock);
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
            end else if (!bus.mem_request) begin
                in_req = 1'b0;
            end else begin
                if (!in_req) begin
                    in_req   = 1'b1;
                    cap_addr = bus.mem_address;
                    cap_data = bus.mem_wdata;
                    wait_cnt = 0;
                end else if (bus.mem_address !== cap_addr || bus.mem_wdata !== cap_data) begin
                    stab_err++;
                end
                if (ack_en && wait_cnt >= ack_delay) begin
                    bus.mem_ack = 1'b1;
                    wr_addr_q.push_back(cap_addr);
                    wr_data_q.push_back(cap_data);
                    in_req = 1'b0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // UART transmitter model: completes each tx two cycles after tx_valid.
    initial begin
        int tx_wait;
        bus.tx_complete = 1'b0;
        tx_wait = 0;
        forever begin
            @(negedge clock);
            if (bus.tx_complete) begin
                bus.tx_complete = 1'b0;
            end else if (bus.tx_valid) begin
                if (tx_wait == 2) begin
                    bus.tx_complete = 1'b1;
                    tx_q.push_back(bus.tx_data);
                    tx_cycle = cycle;
                    tx_wait  = 0;
                end else begin
                    tx_wait++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (bus.boot_start) begin
                boot_cnt++;
                boot_cycle     = cycle;
                boot_addr_seen = bus.boot_address;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        tx_q.delete();
        boot_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        bus.rx_data     = b;
        bus.rx_complete = 1'b1;
        @(negedge clock);
        bus.rx_complete = 1'b0;
        repeat (5) @(negedge clock);
    endtask

    task automatic send_pkt(input byte_q_t pkt);
        foreach (pkt[i]) send_byte(pkt[i]);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000 && bus.busy; i++) @(negedge clock);
        check_eq({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
        repeat (4) @(negedge clock);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_tx_valid"}, {31'd0, bus.tx_valid}, 32'd0);
        check_eq({tag, "_tx_data"}, {24'd0, bus.tx_data}, 32'd0);
        check_eq({tag, "_mem_req"}, {31'd0, bus.mem_request}, 32'd0);
        check_eq({tag, "_mem_addr"}, bus.mem_address, 32'd0);
        check_eq({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        check_eq({tag, "_boot_start"}, {31'd0, bus.boot_start}, 32'd0);
        check_eq({tag, "_boot_addr"}, bus.boot_address, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    byte_q_t pkt;

    initial begin
        bus.rx_complete = 1'b0;
        bus.rx_data     = '0;
        reset           = 1'b1;
        repeat (3) @(negedge clock);
        check_outputs_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // LOAD one word, ack two cycles after request
        clear_logs();
        pkt = '{8'hB0, 8'h00, 8'h10, 8'h00, 8'h00, 8'h01, 8'h00,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hF9};
        send_pkt(pkt);
        wait_done("load1");
        check_eq("load1_nwr", wr_addr_q.size(), 32'd1);
        check_eq("load1_addr", wr_addr_at(0), 32'h0000_1000);
        check_eq("load1_data", wr_data_at(0), 32'hDEAD_BEEF);
        check_eq("load1_ntx", tx_q.size(), 32'd1);
        check_eq("load1_tx", tx_at(0), 32'h06);

        // same packet with a bad checksum: write still happens, NAK
        clear_logs();
        pkt[11] = 8'hF8;
        send_pkt(pkt);
        wait_done("badcs");
        check_eq("badcs_nwr", wr_addr_q.size(), 32'd1);
        check_eq("badcs_data", wr_data_at(0), 32'hDEAD_BEEF);
        check_eq("badcs_tx", tx_at(0), 32'h15);

        // three words at an unaligned address, immediate ack
        clear_logs();
        ack_delay = 0;
        pkt = '{8'hB0, 8'h03, 8'h20, 8'h00, 8'h00, 8'h03, 8'h00,
                8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
                8'h33, 8'h33, 8'h33, 8'h33, 8'h6E};
        send_pkt(pkt);
        wait_done("load3");
        check_eq("load3_nwr", wr_addr_q.size(), 32'd3);
        check_eq("load3_addr0", wr_addr_at(0), 32'h0000_2000);
        check_eq("load3_addr1", wr_addr_at(1), 32'h0000_2004);
        check_eq("load3_addr2", wr_addr_at(2), 32'h0000_2008);
        check_eq("load3_data0", wr_data_at(0), 32'h1111_1111);
        check_eq("load3_data1", wr_data_at(1), 32'h2222_2222);
        check_eq("load3_data2", wr_data_at(2), 32'h3333_3333);
        check_eq("load3_tx", tx_at(0), 32'h06);

        // ack withheld across the second word: overrun, one write, NAK
        clear_logs();
        ack_en = 1'b0;
        pkt = '{8'hB0, 8'h00, 8'h30, 8'h00, 8'h00, 8'h02, 8'h00,
                8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05, 8'h06};
        send_pkt(pkt);
        repeat (5) @(negedge clock);
        ack_en = 1'b1;
        wait_done("ovr");
        check_eq("ovr_nwr", wr_addr_q.size(), 32'd1);
        check_eq("ovr_addr", wr_addr_at(0), 32'h0000_3000);
        check_eq("ovr_data", wr_data_at(0), 32'h0102_0304);
        check_eq("ovr_tx", tx_at(0), 32'h15);

        // good RUN
        clear_logs();
        pkt = '{8'hB1, 8'h00, 8'h00, 8'h01, 8'h00, 8'hB2};
        send_pkt(pkt);
        wait_done("run");
        check_eq("run_tx", tx_at(0), 32'h06);
        check_eq("run_boot_cnt", boot_cnt, 32'd1);
        check_eq("run_boot_timing", boot_cycle, tx_cycle + 1);
        check_eq("run_boot_addr", boot_addr_seen, 32'h0001_0000);
        check_eq("run_nwr", wr_addr_q.size(), 32'd0);

        // bad RUN: NAK, no pulse, boot_address keeps its value
        clear_logs();
        pkt[5] = 8'hB3;
        send_pkt(pkt);
        wait_done("runbad");
        check_eq("runbad_tx", tx_at(0), 32'h15);
        check_eq("runbad_boot_cnt", boot_cnt, 32'd0);
        check_eq("runbad_boot_addr", bus.boot_address, 32'h0001_0000);

        // stall mid-address beyond the timeout
        clear_logs();
        pkt = '{8'hB0, 8'h00, 8'h10};
        send_pkt(pkt);
        repeat (150) @(negedge clock);
        check_eq("tmo_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("tmo_ntx", tx_q.size(), 32'd0);

        // stray byte in IDLE
        send_byte(8'h55);
        check_eq("stray_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("stray_ntx", tx_q.size(), 32'd0);

        // full valid LOAD after the timeout
        clear_logs();
        ack_delay = 2;
        pkt = '{8'hB0, 8'h00, 8'h10, 8'h00, 8'h00, 8'h01, 8'h00,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hF9};
        send_pkt(pkt);
        wait_done("after_tmo");
        check_eq("after_tmo_tx", tx_at(0), 32'h06);
        check_eq("after_tmo_nwr", wr_addr_q.size(), 32'd1);

        // reset mid-DATA with a write pending
        clear_logs();
        ack_en = 1'b0;
        pkt = '{8'hB0, 8'h00, 8'h40, 8'h00, 8'h00, 8'h02, 8'h00,
                8'h44, 8'h33, 8'h22, 8'h11, 8'h55};
        send_pkt(pkt);
        check_eq("midrst_req_pending", {31'd0, bus.mem_request}, 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_outputs_zero("midrst");
        reset  = 1'b0;
        ack_en = 1'b1;
        repeat (60) @(negedge clock);
        check_eq("midrst_ntx", tx_q.size(), 32'd0);
        check_eq("midrst_nwr", wr_addr_q.size(), 32'd0);
        check_eq("midrst_busy", {31'd0, bus.busy}, 32'd0);

        check_eq("mem_hold_stable", stab_err, 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
